// File: rtl/spdif_tx_if.sv
// rtl/spdif_tx_if.sv - sample pop/ack handshake between an upstream source and spdif_tx
interface spdif_tx_if;
  logic [23:0] data_i;
  logic [1:0]  ack_i;
  logic [1:0]  pop_o;

  modport master (output data_i, output ack_i, input pop_o);
  modport slave  (input data_i, input ack_i, output pop_o);
endinterface

// File: rtl/spdif_tx.sv
// rtl/spdif_tx.sv - IEC 60958 transmitter: 192-frame blocks, B/M/W preambles, biphase-mark output
// Optional: SPDIF_TX_HOLD_ON_UNDERRUN_EN resends the last sample (V=0) instead of zero (V=1) on underrun.
module spdif_tx #(
  parameter int CLKDIV = 8
) (
  input  logic         clk,
  input  logic         rst,
  spdif_tx_if.slave    smp_if,
  input  logic [191:0] cdata_i,
  output logic         spdif_o,
  output logic         underrun_o,
  output logic         block_o
);

  localparam logic [7:0] DIV_MAX = 8'(CLKDIV - 1);

  logic [7:0]  r_div;
  logic [6:0]  r_hc;
  logic [7:0]  r_fr;
  logic [23:0] r_shadow_l;
  logic [23:0] r_shadow_r;
  logic [1:0]  r_valid;
  logic [23:0] r_pay;
  logic        r_v;
  logic        r_c;
  logic        r_pol;
  logic        r_out;
  logic [1:0]  r_pop;
  logic        r_under;
  logic        r_block;

  logic        w_tick;
  logic        w_ch;
  logic        w_load;
  logic        w_valid_c;
  logic [23:0] w_shadow_c;
  logic [23:0] w_ld_pay;
  logic        w_ld_v;
  logic [4:0]  w_slot;
  logic        w_par;
  logic [31:0] w_word;
  logic [7:0]  w_pre_pat;
  logic        w_pre_bit;
  logic        w_pol;
  logic        w_nxt;

  assign w_tick     = (r_div == DIV_MAX);
  assign w_ch       = r_hc[6];
  assign w_load     = w_tick && (r_hc[5:0] == 6'd0);
  assign w_valid_c  = w_ch ? r_valid[1] : r_valid[0];
  assign w_shadow_c = w_ch ? r_shadow_r : r_shadow_l;

`ifdef SPDIF_TX_HOLD_ON_UNDERRUN_EN
  assign w_ld_pay = w_shadow_c;
  assign w_ld_v   = 1'b0;
`else
  assign w_ld_pay = w_valid_c ? w_shadow_c : 24'd0;
  assign w_ld_v   = ~w_valid_c;
`endif

  // Word indexed directly by slot; slots 0..3 are preamble and never read from here.
  assign w_slot = r_hc[5:1];
  assign w_par  = ^{r_c, r_v, r_pay};
  assign w_word = {w_par, r_c, 1'b0, r_v, r_pay, 4'b0000};

  assign w_pre_pat = w_ch ? 8'b11100100 : ((r_fr == 8'd0) ? 8'b11101000 : 8'b11100010);
  assign w_pre_bit = w_pre_pat[3'd7 - r_hc[2:0]];
  // Preamble polarity follows the line level just before its first half-cell.
  assign w_pol     = (r_hc[5:0] == 6'd0) ? r_out : r_pol;

  always_comb begin
    w_nxt = r_out;
    if (w_slot < 5'd4)
      w_nxt = w_pre_bit ^ w_pol;
    else if (!r_hc[0])
      w_nxt = ~r_out;
    else if (w_word[w_slot])
      w_nxt = ~r_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div      <= 8'd0;
      r_hc       <= 7'd0;
      r_fr       <= 8'd0;
      r_shadow_l <= 24'd0;
      r_shadow_r <= 24'd0;
      r_valid    <= 2'b00;
      r_pay      <= 24'd0;
      r_v        <= 1'b0;
      r_c        <= 1'b0;
      r_pol      <= 1'b0;
      r_out      <= 1'b0;
      r_pop      <= 2'b00;
      r_under    <= 1'b0;
      r_block    <= 1'b0;
    end else begin
      r_div   <= w_tick ? 8'd0 : r_div + 8'd1;
      r_pop   <= 2'b00;
      r_under <= 1'b0;
      r_block <= 1'b0;

      if (smp_if.ack_i[0]) r_shadow_l <= smp_if.data_i;
      if (smp_if.ack_i[1]) r_shadow_r <= smp_if.data_i;

      // An ack coinciding with the load refills valid for the following subframe.
      if (smp_if.ack_i[0])
        r_valid[0] <= 1'b1;
      else if (w_load && !w_ch)
        r_valid[0] <= 1'b0;
      if (smp_if.ack_i[1])
        r_valid[1] <= 1'b1;
      else if (w_load && w_ch)
        r_valid[1] <= 1'b0;

      if (w_tick) begin
        r_out <= w_nxt;
        r_hc  <= r_hc + 7'd1;
        if (r_hc[5:0] == 6'd0)
          r_pol <= r_out;
        if (r_hc == 7'd127)
          r_fr <= (r_fr == 8'd191) ? 8'd0 : r_fr + 8'd1;
        if (w_load) begin
          r_pay   <= w_ld_pay;
          r_v     <= w_ld_v;
          r_c     <= cdata_i[r_fr];
          r_under <= ~w_valid_c;
          r_pop   <= w_ch ? 2'b01 : 2'b10;
          r_block <= !w_ch && (r_fr == 8'd0);
        end
      end
    end
  end

  assign smp_if.pop_o = r_pop;
  assign spdif_o      = r_out;
  assign underrun_o   = r_under;
  assign block_o      = r_block;

endmodule

// File: tb/tb_spdif_tx.sv
// tb/tb_spdif_tx.sv - directed bench: decodes spdif_tx output at CLKDIV=8 and CLKDIV=2
module tb_spdif_tx;

`ifdef SPDIF_TX_HOLD_ON_UNDERRUN_EN
  localparam logic HOLD = 1'b1;
`else
  localparam logic HOLD = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst8, rst2;
  logic [191:0] cdata8, cdata2;
  logic         spdif8, under8, block8;
  logic         spdif2, under2, block2;
  logic [23:0]  l8, r8, l2, r2;
  logic         skip_req;
  logic         skip_done;

  spdif_tx_if if8 ();
  spdif_tx_if if2 ();

  spdif_tx #(.CLKDIV(8)) u_dut8 (
    .clk(clk), .rst(rst8), .smp_if(if8), .cdata_i(cdata8),
    .spdif_o(spdif8), .underrun_o(under8), .block_o(block8)
  );

  spdif_tx #(.CLKDIV(2)) u_dut2 (
    .clk(clk), .rst(rst2), .smp_if(if2), .cdata_i(cdata2),
    .spdif_o(spdif2), .underrun_o(under2), .block_o(block2)
  );

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  int     und8 = 0, und2 = 0, blk8 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (under8) und8 <= und8 + 1;
    if (under2) und2 <= und2 + 1;
    if (block8) blk8 <= blk8 + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Source model for the CLKDIV=8 instance; one R ack can be withheld on request.
  initial begin
    skip_done   = 1'b0;
    if8.ack_i   = 2'b00;
    if8.data_i  = 24'd0;
    forever begin
      @(negedge clk);
      if (if8.pop_o[1]) begin
        repeat (3) @(negedge clk);
        if (skip_req && !skip_done) begin
          skip_done = 1'b1;
        end else begin
          if8.data_i = r8;
          if8.ack_i  = 2'b10;
          @(negedge clk);
          if8.ack_i  = 2'b00;
        end
      end else if (if8.pop_o[0]) begin
        repeat (3) @(negedge clk);
        if8.data_i = l8;
        if8.ack_i  = 2'b01;
        @(negedge clk);
        if8.ack_i  = 2'b00;
      end
    end
  end

  initial begin
    if2.ack_i  = 2'b00;
    if2.data_i = 24'd0;
    forever begin
      @(negedge clk);
      if (if2.pop_o != 2'b00) begin
        logic [1:0] p;
        p = if2.pop_o;
        repeat (2) @(negedge clk);
        if2.data_i = p[1] ? r2 : l2;
        if2.ack_i  = p;
        @(negedge clk);
        if2.ack_i  = 2'b00;
      end
    end
  end

  task automatic wait_block(input logic which, input int lim);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (which ? block2 : block8) begin
        ok = 1'b1;
        break;
      end
    end
    check(which ? "d2_block_sync" : "d8_block_sync", 32'(ok), 32'd1);
  endtask

  // Entered at the sample point of half-cell 0; returns at the sample point of half-cell 127.
  task automatic dec_frame(input logic which, input int f, input logic b_frame,
                           input logic [23:0] el, input logic evl,
                           input logic [23:0] er, input logic evr,
                           input logic ec, inout logic lvl);
    int          div;
    int          base;
    logic [127:0] h;
    logic [7:0]  pat;
    logic [7:0]  exp_pat;
    logic [27:0] bits;
    logic        last, a, b, code;
    string       nm;
    div = which ? 2 : 8;
    for (int i = 0; i < 128; i++) begin
      if (i > 0) repeat (div) @(negedge clk);
      h[i] = which ? spdif2 : spdif8;
    end
    for (int s = 0; s < 2; s++) begin
      base = s * 64;
      nm = $sformatf("%s_f%0d_%s", which ? "d2" : "d8", f, (s == 0) ? "L" : "R");
      for (int k = 0; k < 8; k++) pat[7 - k] = h[base + k] ^ lvl;
      exp_pat = (s == 1) ? 8'hE4 : (b_frame ? 8'hE8 : 8'hE2);
      last = h[base + 7];
      code = 1'b1;
      for (int sl = 4; sl < 32; sl++) begin
        a = h[base + 2 * sl];
        b = h[base + 2 * sl + 1];
        if (a == last) code = 1'b0;
        bits[sl - 4] = a ^ b;
        last = b;
      end
      lvl = last;
      check({nm, "_pre"}, 32'(pat), 32'(exp_pat));
      check({nm, "_pay"}, 32'(bits[23:0]), 32'(s ? er : el));
      check({nm, "_v"}, 32'(bits[24]), 32'(s ? evr : evl));
      check({nm, "_u"}, 32'(bits[25]), 32'd0);
      check({nm, "_c"}, 32'(bits[26]), 32'(ec));
      check({nm, "_par"}, 32'(^bits), 32'd0);
      check({nm, "_bmc"}, 32'(code), 32'd1);
    end
  endtask

  initial begin
    rst8     = 1'b1;
    rst2     = 1'b1;
    cdata8   = 192'd4;
    cdata2   = 192'd2;
    l8       = 24'h000001;
    r8       = 24'h800000;
    l2       = 24'hFFFFFF;
    r2       = 24'h000000;
    skip_req = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_spdif8", 32'(spdif8), 32'd0);
    check("rst_pop8", 32'(if8.pop_o), 32'd0);
    check("rst_under8", 32'(under8), 32'd0);
    check("rst_block8", 32'(block8), 32'd0);
    check("rst_spdif2", 32'(spdif2), 32'd0);
    check("rst_pop2", 32'(if2.pop_o), 32'd0);
    rst8 = 1'b0;
    rst2 = 1'b0;

    fork
      begin
        logic lvl;
        wait_block(1'b0, 40);
        lvl = 1'b0;
        for (int f = 0; f < 5; f++) begin
          if (f == 4) skip_req = 1'b1;
          if (f > 0) repeat (8) @(negedge clk);
          dec_frame(1'b0, f, f == 0,
                    (f == 0) ? 24'd0 : 24'h000001, (f == 0) ? ~HOLD : 1'b0,
                    (f == 4) ? (HOLD ? 24'h800000 : 24'd0) : 24'h800000,
                    (f == 4) ? ~HOLD : 1'b0,
                    f == 2, lvl);
          if (f == 3) check("d8_under_f3", 32'(und8), 32'd1);
        end
        check("d8_under_f4", 32'(und8), 32'd2);
        repeat (8 + 31 * 8 + 4) @(negedge clk);
        rst8 = 1'b1;
        #1;
        check("midrst_spdif8", 32'(spdif8), 32'd0);
        check("midrst_pop8", 32'(if8.pop_o), 32'd0);
        @(negedge clk);
        rst8 = 1'b0;
        wait_block(1'b0, 40);
        lvl = 1'b0;
        dec_frame(1'b0, 100, 1'b1, 24'd0, ~HOLD, 24'h800000, 1'b0, 1'b0, lvl);
        check("d8_under_rst", 32'(und8), 32'd3);
      end
      begin
        longint     t[4];
        logic [1:0] pv[4];
        int         n;
        longint     lim;
        n   = 0;
        lim = cyc + 3000;
        for (int i = 0; i < 4; i++) begin
          t[i]  = 0;
          pv[i] = 2'b00;
        end
        while (n < 4 && cyc < lim) begin
          @(negedge clk);
          if (if8.pop_o != 2'b00) begin
            t[n]  = cyc;
            pv[n] = if8.pop_o;
            n++;
          end
        end
        check("pop_count", 32'(n), 32'd4);
        check("pop0_bit", 32'(pv[0]), 32'd2);
        check("pop1_bit", 32'(pv[1]), 32'd1);
        check("pop2_bit", 32'(pv[2]), 32'd2);
        check("pop3_bit", 32'(pv[3]), 32'd1);
        check("pop_gap01", 32'(t[1] - t[0]), 32'd512);
        check("pop_gap12", 32'(t[2] - t[1]), 32'd512);
        check("pop_gap23", 32'(t[3] - t[2]), 32'd512);
      end
      begin
        logic   lvl;
        longint t0;
        wait_block(1'b1, 20);
        t0  = cyc;
        lvl = 1'b0;
        for (int f = 0; f < 3; f++) begin
          if (f > 0) repeat (2) @(negedge clk);
          dec_frame(1'b1, f, f == 0,
                    (f == 0) ? 24'd0 : 24'hFFFFFF, (f == 0) ? ~HOLD : 1'b0,
                    24'h000000, 1'b0, f == 1, lvl);
        end
        check("d2_under", 32'(und2), 32'd1);
        wait_block(1'b1, 50000);
        check("d2_block_period", 32'(cyc - t0), 32'd49152);
      end
    join

    check("d8_block_count", 32'(blk8), 32'd2);
    check("d8_under_total", 32'(und8), 32'd3);
    check("d2_under_total", 32'(und2), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spdif_tx.md
Name: spdif_tx

Overview:
- S/PDIF (IEC 60958) transmitter; the transmit counterpart of spdif_dai_varclk.
- Pulls 24-bit stereo samples from an upstream source (resampler or async_fifo read side) with the same pop/ack handshake that dac_drv uses.
- Builds 192-frame blocks with channel status, parity and B/M/W preambles, then biphase-mark encodes them onto one output pin.
- Sits in the clk491520 domain, driving an optical or coax output stage.

Parameters:
- CLKDIV, 8, clk cycles per biphase half-cell; 49.152 MHz / 8 = 6.144 MHz = 128*fs at 48 kHz. Legal range 2..255.

Ports:
- clk  in  1  system clock, e.g. clk491520
- rst  in  1  asynchronous, active-high reset
- data_i  in  24  sample data, two's complement, valid with ack_i
- ack_i  in  2  one-cycle strobe; bit 0 = left sample, bit 1 = right sample
- pop_o  out  2  one-cycle sample request; bit 0 = left, bit 1 = right
- cdata_i  in  192  channel status block; bit n is sent in frame n, both subframes
- spdif_o  out  1  biphase-mark encoded serial output
- underrun_o  out  1  one-cycle pulse when a subframe loads without a fresh sample
- block_o  out  1  one-cycle pulse at the first half-cell of frame 0

Behaviour:
- Reset values: spdif_o=0, pop_o=0, underrun_o=0, block_o=0. All counters = 0. Both shadow registers = 0, valid flags = 0.
- Tick generator: divider counts 0..CLKDIV-1. tick is asserted when the count equals CLKDIV-1. All encoder state advances only on tick.
- hc counter: 0..127 half-cells per frame. Subframe L occupies hc 0..63, subframe R occupies hc 64..127. slot = hc[5:1]; the half-cell index within a slot is hc[0].
- fr counter: 0..191, increments on the tick where hc wraps 127->0; wraps 191->0.
- Prefetch requests:
  - On the tick where hc becomes 0, pop_o[1] pulses for one clk.
  - On the tick where hc becomes 64, pop_o[0] pulses for one clk.
- Sample capture: ack_i[c] at any clk writes data_i into shadow[c] and sets valid[c]. If ack_i[0] and ack_i[1] are both high, data_i is written to both shadows. A later ack overwrites an earlier one.
- Subframe load, on the tick where hc becomes 0 (c=L) or 64 (c=R):
  - If valid[c]=1: payload = shadow[c], V=0.
  - If valid[c]=0: payload = 0, V=1, and underrun_o pulses.
  - valid[c] is cleared. An ack arriving on the same clk as the load sets valid for the next subframe.
- Subframe slot layout:
  - Slots 0-3: preamble.
  - Slots 4-27: payload bits 0..23, LSB first.
  - Slot 28: V. Slot 29: U, always 0. Slot 30: C = cdata_i[fr], sampled at the load.
  - Slot 31: P, chosen so that slots 4..31 carry even parity.
- Preambles are 8 half-cells, sent verbatim when the previous output level is 0 and inverted when it is 1:
  - B (L subframe, fr=0): 11101000
  - M (L subframe, fr!=0): 11100010
  - W (R subframe): 11100100
- Biphase-mark coding for slots 4..31:
  - spdif_o toggles at the start of every slot.
  - spdif_o toggles again at mid-slot when the bit is 1.
- Timing and status:
  - spdif_o is registered and changes exactly one clk after tick.
  - block_o pulses on the clk where the B preamble starts.
- The first L subframe after reset is always an underrun: V=1, zero payload.
- rst asserted mid-frame returns all state to reset values immediately. The stream restarts with a B preamble at fr=0 after release.

Optional Feature:
- Macro: SPDIF_TX_HOLD_ON_UNDERRUN_EN.
- Defined: on underrun the transmitter resends the previous sample of that channel with V=0, and valid is still cleared. underrun_o still pulses.
- Undefined: underrun sends zero payload with V=1, as described above.

Test Plan:
- CLKDIV=8, ack L=24'h000001 and R=24'h800000 within each pop window. Decode the stream with a bench model or spdif_dai_varclk. Required: decoded L=000001, R=800000, V=0, parity correct in every subframe, preamble sequence B,W,M,W...
- cdata_i = 192'h1 << 2 (copy bit set). Required: C=1 only in frame 2, in both subframes. block_o pulses once every 192*128*8 = 196608 clk.
- Withhold ack for R in one frame. Required: exactly one underrun_o pulse and that R subframe has payload 0 with V=1. With SPDIF_TX_HOLD_ON_UNDERRUN_EN defined: the previous R value is resent with V=0.
- Immediately after reset, check the first frame. Required: L is an underrun, then normal operation. Measure pop_o pulse spacing: 64*CLKDIV clk, alternating bit 1 then bit 0.
- Payload 24'hFFFFFF then 24'h000000. Required: exactly 2 or 1 transitions per slot as coded, and no run longer than 3 half-cells outside preambles. CLKDIV=2 passes the same checks.
- Assert rst for 1 clk in the middle of slot 15. Required: spdif_o=0 and pop_o=0 within the same cycle. After release, the first preamble is B and fr=0.
